// File: rtl/lab08_soc_otg_hpi_irq_pio.sv
// Avalon-MM input PIO for the CY7C67200 HPI pins: synchronizer, sticky edge capture, maskable level irq.
// Latency: pin->DATA SYNC_STAGES clks, pin->EDGE/irq SYNC_STAGES+1 clks; readdata zero-wait, no backpressure.
// Build macro OTG_PIO_BIT_CLEAR_EN: EDGE writes are write-1-to-clear; otherwise any EDGE write clears all bits.
module lab08_soc_otg_hpi_irq_pio #(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int             PW         = $clog2(SYNC_STAGES + 2);
   localparam logic [PW-1:0]  PRIME_DONE = PW'(SYNC_STAGES + 1);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
   logic [WIDTH-1:0]                  prev_q, prev_d;
   logic [WIDTH-1:0]                  mask_q, mask_d;
   logic [WIDTH-1:0]                  edgecap_q, edgecap_d;
   logic [PW-1:0]                     prime_q, prime_d;

   logic [WIDTH-1:0] sync_val;
   logic [WIDTH-1:0] rise, fall, edge_sel, edge_hit;
   logic             wr_en;
   logic [31:0]      rd_data;
   logic             wd_unused;

   assign sync_val  = stage_q[SYNC_STAGES-1];
   assign wr_en     = chipselect & ~write_n;
   assign wd_unused = ^writedata;

   always_comb begin
      stage_d = {stage_q[SYNC_STAGES-2:0], in_port};
      prev_d  = sync_val;
      prime_d = (prime_q == PRIME_DONE) ? prime_q : prime_q + PW'(1);
   end

   // Detection stays off until both sync_q and prev hold post-reset samples,
   // so a pin already high at reset release is never seen as a rising edge.
   always_comb begin
      rise = sync_val & ~prev_q;
      fall = ~sync_val & prev_q;
      if (EDGE_TYPE == 0) begin
         edge_sel = rise;
      end else if (EDGE_TYPE == 1) begin
         edge_sel = fall;
      end else begin
         edge_sel = rise | fall;
      end
      edge_hit = (prime_q == PRIME_DONE) ? edge_sel : '0;
   end

   always_comb begin
      mask_d = mask_q;
      if (wr_en && address == ADDR_MASK) begin
         mask_d = writedata[WIDTH-1:0];
      end
   end

   // Clear is applied first and new edges OR'd in after, so an edge in the
   // same cycle as a clear survives.
   always_comb begin
      edgecap_d = edgecap_q;
      if (wr_en && address == ADDR_EDGE) begin
`ifdef OTG_PIO_BIT_CLEAR_EN
         edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
`else
         edgecap_d = '0;
`endif
      end
      edgecap_d = edgecap_d | edge_hit;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stage_q   <= '0;
         prev_q    <= '0;
         mask_q    <= '0;
         edgecap_q <= '0;
         prime_q   <= '0;
      end else begin
         stage_q   <= stage_d;
         prev_q    <= prev_d;
         mask_q    <= mask_d;
         edgecap_q <= edgecap_d;
         prime_q   <= prime_d;
      end
   end

   always_comb begin
      rd_data = '0;
      case (address)
         ADDR_DATA: rd_data[WIDTH-1:0] = sync_val;
         ADDR_MASK: rd_data[WIDTH-1:0] = mask_q;
         ADDR_EDGE: rd_data[WIDTH-1:0] = edgecap_q;
         default:   rd_data = '0;
      endcase
   end

   assign readdata = rd_data;
   assign irq      = |(edgecap_q & mask_q);

endmodule
